// File: rtl/img_pkg.sv
// Shared defaults and state encoding for the image UART transmitter.
package img_pkg;
    localparam int IMG_WIDTH       = 64;
    localparam int IMG_HEIGHT      = 64;
    localparam int IMG_BIT_DEPTH   = 8;
    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND
    } tx_state_t;
endpackage

// File: rtl/img_uart_tx_if.sv
// Byte handshake between the frame sequencer and the bit serializer.
interface img_uart_tx_if
    import img_pkg::*;
#(
    parameter int BIT_DEPTH = IMG_BIT_DEPTH
);
    logic                 valid;
    logic [BIT_DEPTH-1:0] data;
    logic                 ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: takes one byte on the handshake and shifts it out LSB first.
module uart_tx_byte
    import img_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 50
) (
    input  logic         clk_in,
    input  logic         rst_in_n,
    img_uart_tx_if.slave byte_if,
    output logic         tx_out
);
    localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD + 1);

    logic                       busy_q, busy_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic                       baud_end;
    logic                       last_cycle;

    assign baud_end   = (baud_q == BAUD_W'(CLOCKS_PER_BAUD - 1));
    assign last_cycle = busy_q && baud_end && (bit_q == 4'(UART_FRAME_BITS - 1));
    // Ready in the final stop-bit cycle so the sequencer can leave SEND on that edge.
    assign byte_if.ready = !busy_q || last_cycle;
    assign tx_out        = busy_q ? shift_q[0] : 1'b1;

    // Load a new frame on handshake, otherwise advance baud and bit counters.
    always_comb begin
        busy_d  = busy_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (byte_if.valid && byte_if.ready) begin
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = {1'b1, byte_if.data, 1'b0};
        end else if (busy_q) begin
            if (baud_end) begin
                baud_d = '0;
                if (bit_q == 4'(UART_FRAME_BITS - 1)) begin
                    busy_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[UART_FRAME_BITS-1:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // Serializer state registers; reset returns the line to idle-high.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            busy_q  <= busy_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/img_uart_tx.sv
// Frame sequencer: walks the image BRAM and streams every pixel over UART.
module img_uart_tx
    import img_pkg::*;
#(
    parameter int WIDTH           = IMG_WIDTH,
    parameter int HEIGHT          = IMG_HEIGHT,
    parameter int BIT_DEPTH       = IMG_BIT_DEPTH,
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int READ_LATENCY    = 2,
    parameter int SIGNED_OFFSET   = 0
) (
    input  logic                               clk_in,
    input  logic                               rst_in_n,
    input  logic                               start_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]    read_addr,
    output logic                               read_addr_valid,
    input  logic [BIT_DEPTH-1:0]               pixel_in,
    output logic                               tx_out,
    output logic                               busy_out,
    output logic                               done_out
);
    localparam int ADDR_W = $clog2(WIDTH * HEIGHT);
    localparam int WAIT_W = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    // Inverting the MSB maps two's-complement gradients onto offset-binary.
    localparam logic [BIT_DEPTH-1:0] MSB_FLIP =
        (SIGNED_OFFSET != 0) ? {1'b1, {(BIT_DEPTH-1){1'b0}}} : '0;

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              done_q, done_d;

    img_uart_tx_if #(.BIT_DEPTH(BIT_DEPTH)) byte_bus ();

    // Hand the pixel to the serializer in the last WAIT cycle, when BRAM data is valid.
    assign byte_bus.valid = (state_q == WAIT) && (wait_q == WAIT_W'(READ_LATENCY - 1));
    assign byte_bus.data  = pixel_in ^ MSB_FLIP;

    assign read_addr       = addr_q;
    assign read_addr_valid = (state_q == FETCH);
    assign busy_out        = (state_q != IDLE);
    assign done_out        = done_q;

    uart_tx_byte #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_ser (
        .clk_in  (clk_in),
        .rst_in_n(rst_in_n),
        .byte_if (byte_bus),
        .tx_out  (tx_out)
    );

    // Next-state logic for the fetch/wait/send sequence and the pixel address.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (byte_bus.valid) state_d = SEND;
                else                wait_d  = wait_q + 1'b1;
            end
            SEND: begin
                if (byte_bus.ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any frame and rewinds to pixel 0.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
        end
    end
endmodule
